// File: rtl/fault_resp_pkg.sv
// Shared types and helpers for the fault-response monitor.
// Latency: n/a (types, constants and a combinational MISR step function).
// Backpressure: n/a.
// Contents: FSM state enum, default MISR polynomial, misr_next().
package fault_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GOLDEN  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

  // One MISR step for a register of width w (w <= 64). Operands are carried
  // in 64-bit containers so the helper is usable for any DATA_W; callers
  // truncate the result back to their own width.
  function automatic logic [63:0] misr_next(input logic [63:0] sig,
                                            input logic [63:0] data,
                                            input logic [63:0] poly,
                                            input int unsigned w);
    logic [63:0] mask;
    logic        msb;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    msb  = |(sig & (64'd1 << (w - 1)));
    return (((sig << 1) ^ (msb ? poly : 64'd0) ^ data) & mask);
  endfunction

endpackage

// File: rtl/fault_resp_golden_buf.sv
// Per-step golden sample store: written during the golden pass, compared during compare passes.
// Latency: write lands at the next clock edge; compare result is combinational.
// Backpressure: none; the caller only writes/compares on accepted samples.
// Ports: clk; wr_en/wr_addr/wr_data write port; cmp_addr/cmp_data in, cmp_mis out.
module fault_resp_golden_buf #(
  parameter int DATA_W = 16,
  parameter int STEPS  = 128
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(STEPS)-1:0] cmp_addr,
  input  logic [DATA_W-1:0]        cmp_data,
  output logic                     cmp_mis
);

  // No reset: entries are only read after a complete golden pass rewrote them.
  logic [DATA_W-1:0] mem [STEPS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign cmp_mis = (mem[cmp_addr] != cmp_data);

endmodule

// File: rtl/fault_resp_monitor.sv
// Compacts one stimulus pass of DUT output words into a MISR signature; golden pass records the
// reference, later passes emit one detected/undetected verdict per fault ID.
// Latency: result valid 1 cycle after the last sample; res_* held until res_valid & res_ready.
// Ports: clk/rst (sync, active-high); pass_start/pass_golden/pass_fid; sample_valid/sample_data;
//   busy; res_valid/res_ready and res_* result fields; err_proto sticky flag.
// Optional macro FAULT_RESP_FIRST_FAIL_EN: per-step golden buffer with first-mismatch report.
module fault_resp_monitor
  import fault_resp_pkg::*;
#(
  parameter int                DATA_W = 16,
  parameter int                STEPS  = 128,
  parameter int                FID_W  = 16,
  parameter logic [DATA_W-1:0] POLY   = DATA_W'(DEFAULT_POLY)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pass_start,
  input  logic                     pass_golden,
  input  logic [FID_W-1:0]         pass_fid,
  input  logic                     sample_valid,
  input  logic [DATA_W-1:0]        sample_data,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [FID_W-1:0]         res_fid,
  output logic                     res_golden,
  output logic                     res_detected,
  output logic [DATA_W-1:0]        res_signature,
  output logic [$clog2(STEPS)-1:0] res_first_step,
  output logic                     res_step_hit,
  output logic                     err_proto
);

  localparam int STEP_W = $clog2(STEPS);

  state_t            state;
  logic [FID_W-1:0]  fid_q;
  logic              golden_q;
  logic [DATA_W-1:0] sig_q;
  logic [STEP_W-1:0] step_q;
  logic [DATA_W-1:0] golden_sig;
  logic              golden_ok;
  logic              detected_q;

  logic              accept;
  logic              last;
  logic              any_mis;
  logic [DATA_W-1:0] sig_next;

  assign accept   = sample_valid && (state == ST_GOLDEN || state == ST_COMPARE);
  assign last     = accept && (step_q == STEP_W'(STEPS - 1));
  assign sig_next = DATA_W'(misr_next(64'(sig_q), 64'(sample_data), 64'(POLY), DATA_W));

`ifdef FAULT_RESP_FIRST_FAIL_EN
  logic              cmp_mis;
  logic              step_mis;
  logic              mis_seen;
  logic [STEP_W-1:0] first_step_q;

  fault_resp_golden_buf #(
    .DATA_W (DATA_W),
    .STEPS  (STEPS)
  ) u_golden_buf (
    .clk      (clk),
    .wr_en    (accept && state == ST_GOLDEN),
    .wr_addr  (step_q),
    .wr_data  (sample_data),
    .cmp_addr (step_q),
    .cmp_data (sample_data),
    .cmp_mis  (cmp_mis)
  );

  // Without a completed golden pass the buffer holds nothing meaningful.
  assign step_mis = accept && state == ST_COMPARE && golden_ok && cmp_mis;
  // Include a mismatch on the final sample, which has not reached mis_seen yet.
  assign any_mis  = mis_seen || step_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_seen     <= 1'b0;
      first_step_q <= '0;
    end else if (state == ST_IDLE && pass_start) begin
      mis_seen     <= 1'b0;
      first_step_q <= '0;
    end else if (step_mis && !mis_seen) begin
      mis_seen     <= 1'b1;
      first_step_q <= step_q;
    end
  end

  assign res_first_step = first_step_q;
  assign res_step_hit   = mis_seen;
`else
  assign any_mis        = 1'b0;
  assign res_first_step = '0;
  assign res_step_hit   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fid_q      <= '0;
      golden_q   <= 1'b0;
      sig_q      <= '0;
      step_q     <= '0;
      golden_sig <= '0;
      golden_ok  <= 1'b0;
      detected_q <= 1'b0;
      err_proto  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pass_start) begin
            fid_q      <= pass_fid;
            golden_q   <= pass_golden;
            sig_q      <= '0;
            step_q     <= '0;
            detected_q <= 1'b0;
            state      <= pass_golden ? ST_GOLDEN : ST_COMPARE;
            // A compare pass with no reference can never yield a real verdict.
            if (!pass_golden && !golden_ok) begin
              err_proto <= 1'b1;
            end
          end
        end
        ST_GOLDEN, ST_COMPARE: begin
          if (pass_start) begin
            err_proto <= 1'b1;
          end
          if (accept) begin
            sig_q  <= sig_next;
            step_q <= step_q + 1'b1;
          end
          if (last) begin
            state <= ST_REPORT;
            if (state == ST_GOLDEN) begin
              golden_sig <= sig_next;
              golden_ok  <= 1'b1;
            end else begin
              detected_q <= golden_ok && ((sig_next != golden_sig) || any_mis);
            end
          end
        end
        ST_REPORT: begin
          if (pass_start) begin
            err_proto <= 1'b1;
          end
          if (res_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // fid_q, golden_q and sig_q only move while a pass runs, so they are stable in REPORT.
  assign busy          = (state != ST_IDLE);
  assign res_valid     = (state == ST_REPORT);
  assign res_fid       = fid_q;
  assign res_golden    = golden_q;
  assign res_signature = sig_q;
  assign res_detected  = detected_q;

endmodule
